// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, sequencer state encoding and the
// round/shift/saturate helper used by the sequential FIR engines.
package fir_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int COEF_W_DEF    = 8;
  localparam int TAPS_DEF      = 16;
  localparam int OUT_SHIFT_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } fir_state_e;

  // Half-up rounding, arithmetic shift, then clip to a data_w-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int data_w);
    logic signed [63:0] tmp;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    tmp = acc;
    if (shift > 0) begin
      tmp = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (tmp > hi) begin
      tmp = hi;
    end else if (tmp < lo) begin
      tmp = lo;
    end
    return tmp;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write per accepted sample at the internal write
// pointer, one combinational indexed read for the MAC loop.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic        [AW-1:0]     raddr,
  output logic signed [DATA_W-1:0] rdata,
  output logic        [AW-1:0]     wp
);

  logic signed [DATA_W-1:0] line_q [TAPS];
  logic signed [DATA_W-1:0] line_d [TAPS];
  logic        [AW-1:0]     wp_q;
  logic        [AW-1:0]     wp_d;

  // TAPS is a power of two, so the pointer wraps without an explicit modulo.
  always_comb begin
    line_d = line_q;
    wp_d   = wp_q;
    if (we) begin
      line_d[wp_q] = wdata;
      wp_d         = wp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        line_q[i] <= '0;
      end
      wp_q <= '0;
    end else begin
      line_q <= line_d;
      wp_q   <= wp_d;
    end
  end

  assign rdata = line_q[raddr];
  assign wp    = wp_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiplier and accumulator stepped over TAPS
// coefficients per accepted sample, with valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes honoured
//   MAC   | one tap per cycle, k = 0..TAPS-1
//   ROUND | round, shift and saturate acc into out_sample
//   HOLD  | out_valid high until out_ready
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF,
  localparam int AW       = $clog2(TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     busy
);

  fir_state_e               state_q, state_d;
  logic        [AW-1:0]     k_q, k_d;
  logic        [AW-1:0]     base_q, base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];

  logic                            line_we;
  logic        [AW-1:0]            rd_addr;
  logic signed [DATA_W-1:0]        rd_data;
  logic        [AW-1:0]            wp;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         prod_ext;

  assign line_we  = (state_q == ST_IDLE) && in_ready_q && in_valid;
  assign rd_addr  = base_q - k_q;
  assign prod     = rd_data * coef_q[k_q];
  assign prod_ext = ACC_W'(prod);

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_line (
    .clk   (clk),
    .rst   (rst),
    .we    (line_we),
    .wdata (in_sample),
    .raddr (rd_addr),
    .rdata (rd_data),
    .wp    (wp)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    acc_d        = acc_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    coef_d       = coef_q;

    // Writes outside IDLE are dropped; an IDLE write lands before the MAC reads it.
    if (coef_we && (state_q == ST_IDLE)) begin
      coef_d[coef_addr] = coef_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (line_we) begin
          acc_d   = '0;
          k_d     = '0;
          base_d  = wp;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == AW'(TAPS - 1)) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_sample_d = DATA_W'(sat_round(64'(acc_q), OUT_SHIFT, DATA_W));
        out_valid_d  = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      base_q       <= '0;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      base_q       <= base_d;
      acc_q        <= acc_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      coef_q       <= coef_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign busy       = busy_q;

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR engine: one signed multiplier and one accumulator are stepped over TAPS coefficients for each accepted input sample.
- Owns the sample delay line (circular buffer), the coefficient register file and the control FSM.
- Sits between the sample source and the output sink with valid/ready handshakes on both sides.
- It is the area-lean, runtime-configurable alternative to the fully parallel 8-bit FIR datapath.

Parameters:
DATA_W, 8, signed sample width (input and output)
COEF_W, 8, signed coefficient width, Q1.(COEF_W-1) format
TAPS, 16, number of taps; power of two, >= 2
OUT_SHIFT, 7, right shift applied to the accumulator before rounding and saturation
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, localparam)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_sample valid
in_ready  out  1  block can accept a sample
in_sample  in  DATA_W  signed input sample
out_valid  out  1  out_sample valid
out_ready  in  1  sink accepts out_sample
out_sample  out  DATA_W  signed filtered sample
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k
coef_data  in  COEF_W  signed coefficient value
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Outputs: in_ready=0 during rst, out_valid=0, out_sample=0, busy=0.
  - Internal: all delay-line entries=0, all coefficients=0, write pointer wp=0, tap counter k=0, acc=0, state=IDLE.
  - in_ready goes to 1 on the first cycle after rst deasserts.
- FSM states: IDLE, MAC, ROUND, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: write in_sample to line[wp], clear acc, set k=0, latch base=wp, advance wp=wp+1 (mod TAPS), go to MAC.
- MAC:
  - Each cycle: acc <= acc + line[(base-k) mod TAPS] * coef[k], using a full-precision signed product, sign-extended to ACC_W.
  - k increments each cycle. After the k=TAPS-1 accumulation, go to ROUND. MAC lasts exactly TAPS cycles.
- ROUND:
  - out_sample <= sat(( acc + 2^(OUT_SHIFT-1) ) >>> OUT_SHIFT), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid=1; out_sample held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_ready stays 0 until IDLE is re-entered.
- Latency: sample accepted at edge E0 gives out_valid high after edge E0+TAPS+1 (17 for TAPS=16). Minimum issue interval is TAPS+3 cycles with out_ready tied high.
- Arithmetic: the accumulator never wraps for TAPS ≤ 2^($clog2(TAPS)). Rounding is half-up toward +inf before the arithmetic shift. Saturation is applied after the shift.
- Coefficient writes:
  - Honoured only in IDLE. coef_we while busy=1 is dropped silently, with no state change.
  - coef_we and in_valid in the same IDLE cycle: both take effect at that edge, and the new coefficient is used by that sample's MAC.
- in_valid outside IDLE is ignored; the source must hold it, per the standard valid/ready rule.
- Reset mid-operation (any state): abort immediately to reset values. The partially accumulated result is discarded. The delay line and coefficients are cleared.

Decomposition:
- Shared package fir_pkg:
  - state enum encoding (IDLE/MAC/ROUND/HOLD).
  - default DATA_W/COEF_W/TAPS/OUT_SHIFT constants.
  - a sat_round function (round, shift, saturate), shared with future FIR variants.
- One natural sub-module: fir_delay_line (circular TAPS×DATA_W register buffer, write pointer, indexed read, synchronous clear). The FSM, coefficient file and MAC stay in the top module.

Test Plan:
- Passthrough gain: coef[0]=64, others 0; input 100 → out_sample 50, first out_valid 17 cycles after acceptance.
- Impulse response: coef[k]=k+1; input 64 then 15 zeros, out_ready=1 → outputs 1,1,2,2,3,3,4,4,5,5,6,6,7,7,8,8.
- Saturation: all coef=127; sixteen inputs of 127 → last output 127 (clipped). Repeat with -128 inputs → -128.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid stays 1, out_sample stable, in_ready=0. Release → IDLE next cycle, in_ready=1.
- Busy-write drop: write coef[0]=0 during MAC while coef[0]=64 → current and next results still use 64. Rewrite in IDLE → subsequent outputs 0.
- Reset mid-MAC: assert rst at k=8 → next cycle out_valid=0, busy=0. After release, input 100 with coef unset → output 0.
